nvme_cq_doorbell_rx: RTL and testbench

NVME_CQ_DOORBELL_RX -- requirements
Module: nvme_cq_doorbell_rx

---
 rtl/nvme_cq_doorbell_rx_pkg.sv | 16 +
 rtl/nvme_cq_doorbell_rx_if.sv | 25 ++
 rtl/nvme_cq_doorbell_rx_addr_decode.sv | 22 ++
 rtl/nvme_cq_doorbell_rx.sv | 147 ++++++++++++++
 tb/tb_nvme_cq_doorbell_rx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nvme_cq_doorbell_rx_pkg.sv
// Shared NVMe doorbell constants and the doorbell request type.
package nvme_cq_doorbell_rx_pkg;

    localparam logic [31:0] DB_BASE = 32'h0000_1000;
    localparam int          NUM_CQ  = 9;
    localparam int          QID_W   = 4;

    localparam logic ERR_INV_REG = 1'b0;
    localparam logic ERR_INV_VAL = 1'b1;

    typedef struct packed {
        logic [QID_W-1:0] qid;
        logic [31:0]      dat;
    } db_req_t;

endpackage

// File: rtl/nvme_cq_doorbell_rx_if.sv
// Host doorbell write port plus the error report handshake.
interface nvme_cq_doorbell_rx_if
    import nvme_cq_doorbell_rx_pkg::*;
#(
    parameter int C_DB_ADDR_WIDTH = 16
);
    logic                       db_wr_en;
    logic                       db_wr_ready;
    logic [C_DB_ADDR_WIDTH-1:0] db_wr_addr;
    logic [31:0]                db_wr_data;
    logic                       db_err_valid;
    logic                       db_err_code;
    logic [QID_W-1:0]           db_err_qid;
    logic                       db_err_ack;

    modport master (
        output db_wr_en, db_wr_addr, db_wr_data, db_err_ack,
        input  db_wr_ready, db_err_valid, db_err_code, db_err_qid
    );

    modport slave (
        input  db_wr_en, db_wr_addr, db_wr_data, db_err_ack,
        output db_wr_ready, db_err_valid, db_err_code, db_err_qid
    );
endinterface

// File: rtl/nvme_cq_doorbell_rx_addr_decode.sv
// Combinational BAR0 offset to CQ head doorbell decode (stride 0); no state, no backpressure.
module nvme_db_addr_decode
    import nvme_cq_doorbell_rx_pkg::*;
#(
    parameter int C_DB_ADDR_WIDTH = 16
) (
    input  logic [C_DB_ADDR_WIDTH-1:0] addr_i,
    output logic                       hit_o,
    output logic [QID_W-1:0]           qid_o
);
    logic [31:0] addr_ext;
    logic [31:0] rel;

    // CQ y head sits at rel = 8y + 4, so the low three bits must read 3'b100.
    always_comb begin
        addr_ext = 32'(addr_i);
        rel      = addr_ext - DB_BASE;
        hit_o    = (addr_ext >= DB_BASE) && (rel[2:0] == 3'b100) &&
                   (rel[31:3] < 29'(NUM_CQ));
        qid_o    = rel[6:3];
    end
endmodule

// File: rtl/nvme_cq_doorbell_rx.sv
// CQ head doorbell receiver: head/pulse 2 cycles after accept; ready drops only while an error is pending.
// Error checking and reporting are built only with NVME_DB_ERR_CHECK_EN defined.
module nvme_cq_doorbell_rx
    import nvme_cq_doorbell_rx_pkg::*;
#(
    parameter int C_PCIE_ADDR_WIDTH = 48,
    parameter int C_DB_ADDR_WIDTH   = 16
) (
    input  logic                        pcie_user_clk,
    input  logic                        pcie_user_rst_n,
    nvme_cq_doorbell_rx_if.slave        db_if,
    input  logic [NUM_CQ-1:0]           cq_rst_n,
    input  logic [NUM_CQ-1:0]           cq_valid,
    input  logic [8*NUM_CQ-1:0]         cq_size,
    output logic [7:0]                  admin_cq_head_ptr,
    output logic [7:0]                  io_cq1_head_ptr,
    output logic [7:0]                  io_cq2_head_ptr,
    output logic [7:0]                  io_cq3_head_ptr,
    output logic [7:0]                  io_cq4_head_ptr,
    output logic [7:0]                  io_cq5_head_ptr,
    output logic [7:0]                  io_cq6_head_ptr,
    output logic [7:0]                  io_cq7_head_ptr,
    output logic [7:0]                  io_cq8_head_ptr,
    output logic [NUM_CQ-1:0]           cq_head_update
);
    logic             dec_hit;
    logic [QID_W-1:0] dec_qid;
    logic             accept;
    logic             s1_vld_q, s2_vld_q;
    db_req_t          s1_q, s2_q;
    logic             q_live, range_ok, wr_ok;
    logic [7:0]       q_size;
    logic [7:0]       head_q [NUM_CQ];
    logic [7:0]       head_d [NUM_CQ];
    logic [NUM_CQ-1:0] upd_q, upd_d;

    // The host address width carries no logic; it only rejects a degenerate build.
    if (C_PCIE_ADDR_WIDTH > 0) begin : g_dec
        nvme_db_addr_decode #(.C_DB_ADDR_WIDTH(C_DB_ADDR_WIDTH)) u_dec (
            .addr_i (db_if.db_wr_addr),
            .hit_o  (dec_hit),
            .qid_o  (dec_qid)
        );
    end else begin : g_no_dec
        assign dec_hit = 1'b0;
        assign dec_qid = '0;
    end

    assign accept = db_if.db_wr_en && db_if.db_wr_ready;

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= accept && dec_hit;
            if (accept && dec_hit) begin
                s1_q <= '{qid: dec_qid, dat: db_if.db_wr_data};
            end
            s2_vld_q <= s1_vld_q;
            s2_q     <= s1_q;
        end
    end

    always_comb begin
        q_live   = cq_valid[s2_q.qid] && cq_rst_n[s2_q.qid];
        q_size   = cq_size[{s2_q.qid, 3'b000} +: 8];
        range_ok = (s2_q.dat[31:8] == 24'd0) && (s2_q.dat[7:0] <= q_size);
`ifdef NVME_DB_ERR_CHECK_EN
        wr_ok    = s2_vld_q && q_live && range_ok;
`else
        wr_ok    = s2_vld_q && q_live;
`endif
    end

    // Queue clear wins over a same-cycle doorbell commit.
    always_comb begin
        for (int y = 0; y < NUM_CQ; y++) begin
            head_d[y] = head_q[y];
            upd_d[y]  = 1'b0;
            if (!cq_rst_n[y]) begin
                head_d[y] = '0;
            end else if (wr_ok && (s2_q.qid == QID_W'(y))) begin
                head_d[y] = s2_q.dat[7:0];
                upd_d[y]  = 1'b1;
            end
        end
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            for (int y = 0; y < NUM_CQ; y++) head_q[y] <= '0;
            upd_q <= '0;
        end else begin
            for (int y = 0; y < NUM_CQ; y++) head_q[y] <= head_d[y];
            upd_q <= upd_d;
        end
    end

`ifdef NVME_DB_ERR_CHECK_EN
    logic             err_vld_q, err_code_q;
    logic [QID_W-1:0] err_qid_q;
    logic             err_new;

    // Only the first error is latched; later failures in flight are dropped.
    assign err_new = s2_vld_q && !(q_live && range_ok) && !err_vld_q;

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            err_vld_q  <= 1'b0;
            err_code_q <= 1'b0;
            err_qid_q  <= '0;
        end else if (err_vld_q && db_if.db_err_ack) begin
            err_vld_q  <= 1'b0;
            err_code_q <= 1'b0;
            err_qid_q  <= '0;
        end else if (err_new) begin
            err_vld_q  <= 1'b1;
            err_code_q <= q_live ? ERR_INV_VAL : ERR_INV_REG;
            err_qid_q  <= s2_q.qid;
        end
    end

    assign db_if.db_err_valid = err_vld_q;
    assign db_if.db_err_code  = err_code_q;
    assign db_if.db_err_qid   = err_qid_q;
    assign db_if.db_wr_ready  = !err_vld_q;
`else
    assign db_if.db_err_valid = 1'b0;
    assign db_if.db_err_code  = 1'b0;
    assign db_if.db_err_qid   = '0;
    assign db_if.db_wr_ready  = 1'b1;
`endif

    assign admin_cq_head_ptr = head_q[0];
    assign io_cq1_head_ptr   = head_q[1];
    assign io_cq2_head_ptr   = head_q[2];
    assign io_cq3_head_ptr   = head_q[3];
    assign io_cq4_head_ptr   = head_q[4];
    assign io_cq5_head_ptr   = head_q[5];
    assign io_cq6_head_ptr   = head_q[6];
    assign io_cq7_head_ptr   = head_q[7];
    assign io_cq8_head_ptr   = head_q[8];
    assign cq_head_update    = upd_q;
endmodule

// File: tb/tb_nvme_cq_doorbell_rx.sv
// Directed doorbell vectors with a queue-based scoreboard for head pulses and error reports.
module tb_nvme_cq_doorbell_rx;
    import nvme_cq_doorbell_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  cq_rst_n;
    logic [8:0]  cq_valid;
    logic [71:0] cq_size;
    logic [7:0]  h0, h1, h2, h3, h4, h5, h6, h7, h8;
    logic [8:0]  cq_head_update;

    nvme_cq_doorbell_rx_if #(.C_DB_ADDR_WIDTH(16)) db_if ();

    nvme_cq_doorbell_rx #(.C_PCIE_ADDR_WIDTH(48), .C_DB_ADDR_WIDTH(16)) dut (
        .pcie_user_clk     (clk),
        .pcie_user_rst_n   (rst_n),
        .db_if             (db_if),
        .cq_rst_n          (cq_rst_n),
        .cq_valid          (cq_valid),
        .cq_size           (cq_size),
        .admin_cq_head_ptr (h0),
        .io_cq1_head_ptr   (h1),
        .io_cq2_head_ptr   (h2),
        .io_cq3_head_ptr   (h3),
        .io_cq4_head_ptr   (h4),
        .io_cq5_head_ptr   (h5),
        .io_cq6_head_ptr   (h6),
        .io_cq7_head_ptr   (h7),
        .io_cq8_head_ptr   (h8),
        .cq_head_update    (cq_head_update)
    );

    always #5 clk = ~clk;

    typedef struct { int qid; int val; int cyc; } hexp_t;
    typedef struct { int code; int qid; } eexp_t;

    hexp_t hq[$];
    eexp_t eq[$];
    int    exp_head [9];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    bit    err_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_head(int q);
        case (q)
            0: return int'(h0);
            1: return int'(h1);
            2: return int'(h2);
            3: return int'(h3);
            4: return int'(h4);
            5: return int'(h5);
            6: return int'(h6);
            7: return int'(h7);
            default: return int'(h8);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        chk("ready_at_issue", int'(db_if.db_wr_ready), 1);
        db_if.db_wr_en   = 1'b1;
        db_if.db_wr_addr = addr;
        db_if.db_wr_data = data;
    endtask

    task automatic idle();
        @(negedge clk);
        db_if.db_wr_en = 1'b0;
    endtask

    // Called at the issue negedge: commit lands three posedges later.
    task automatic exp_wr(input int q, input int v);
        hq.push_back('{qid: q, val: v, cyc: cyc + 3});
        exp_head[q] = v;
    endtask

    task automatic exp_err(input int code, input int q);
`ifdef NVME_DB_ERR_CHECK_EN
        eq.push_back('{code: code, qid: q});
`endif
    endtask

    task automatic check_heads();
        for (int q = 0; q < 9; q++) chk($sformatf("head%0d", q), get_head(q), exp_head[q]);
    endtask

    task automatic handle_err();
`ifdef NVME_DB_ERR_CHECK_EN
        int t = 0;
        while (!db_if.db_err_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("err_seen", int'(db_if.db_err_valid), 1);
        chk("ready_low", int'(db_if.db_wr_ready), 0);
        wait_cyc(2);
        chk("err_hold", int'(db_if.db_err_valid), 1);
        db_if.db_err_ack = 1'b1;
        @(negedge clk);
        db_if.db_err_ack = 1'b0;
        chk("err_clear", int'(db_if.db_err_valid), 0);
        chk("ready_back", int'(db_if.db_wr_ready), 1);
        wait_cyc(3);
`else
        wait_cyc(6);
`endif
    endtask

    // Scoreboard monitor: every pulse and every rising error report must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cq_head_update != 9'd0) begin
                if (hq.size() == 0) begin
                    chk("unexpected_pulse", int'(cq_head_update), 0);
                end else begin
                    hexp_t e;
                    e = hq.pop_front();
                    chk("pulse_vec", int'(cq_head_update), 1 << e.qid);
                    chk("pulse_head", get_head(e.qid), e.val);
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end
            if (db_if.db_err_valid && !err_prev) begin
                if (eq.size() == 0) begin
                    chk("unexpected_err_qid", int'(db_if.db_err_qid), 15);
                end else begin
                    eexp_t e;
                    e = eq.pop_front();
                    chk("err_code", int'(db_if.db_err_code), e.code);
                    chk("err_qid", int'(db_if.db_err_qid), e.qid);
                end
            end
            err_prev = db_if.db_err_valid;
        end else begin
            err_prev = 1'b0;
        end
    end

    initial begin
        db_if.db_wr_en   = 1'b0;
        db_if.db_wr_addr = '0;
        db_if.db_wr_data = '0;
        db_if.db_err_ack = 1'b0;
        cq_valid = 9'h1FF;
        cq_rst_n = 9'h1FF;
        cq_size  = {9{8'hFF}};
        cq_size[15:8]  = 8'h0F;
        cq_size[23:16] = 8'h0F;
        cq_size[47:40] = 8'h20;
        for (int q = 0; q < 9; q++) exp_head[q] = 0;

        wait_cyc(3);
        check_heads();
        chk("rst_update", int'(cq_head_update), 0);
        chk("rst_err_valid", int'(db_if.db_err_valid), 0);
        chk("rst_ready", int'(db_if.db_wr_ready), 1);
        rst_n = 1'b1;
        wait_cyc(2);

        // Single write to CQ1
        issue(16'h100C, 32'h5); exp_wr(1, 5);
        idle(); wait_cyc(5);

        // Back-to-back admin then CQ8
        issue(16'h1004, 32'h3); exp_wr(0, 3);
        issue(16'h1044, 32'h7); exp_wr(8, 7);
        idle(); wait_cyc(5);

        // SQ tail, base, and just-past-last-CQ offsets are discarded
        issue(16'h1008, 32'h55);
        issue(16'h1000, 32'h11);
        issue(16'h104C, 32'h1);
        idle(); wait_cyc(5);
        check_heads();

        // Wrap boundary: head == size legal, size+1 illegal
        issue(16'h102C, 32'h20); exp_wr(5, 32'h20);
        issue(16'h102C, 32'h21);
`ifdef NVME_DB_ERR_CHECK_EN
        exp_err(1, 5);
`else
        exp_wr(5, 32'h21);
`endif
        idle(); handle_err();
        check_heads();

        // Out-of-range value to CQ2; a valid write right behind it still completes
        issue(16'h1014, 32'h10);
`ifdef NVME_DB_ERR_CHECK_EN
        exp_err(1, 2);
`else
        exp_wr(2, 32'h10);
`endif
        issue(16'h100C, 32'h9); exp_wr(1, 9);
        idle(); handle_err();
        check_heads();

        // Upper data bits set
        issue(16'h1034, 32'h100);
`ifdef NVME_DB_ERR_CHECK_EN
        exp_err(1, 6);
`else
        exp_wr(6, 0);
`endif
        idle(); handle_err();
        check_heads();

        // Uncreated CQ3: only the first of two in-flight errors is reported
        cq_valid[3] = 1'b0;
        issue(16'h101C, 32'h1); exp_err(0, 3);
        issue(16'h101C, 32'h2);
        idle(); handle_err(); wait_cyc(4);
        check_heads();
        cq_valid[3] = 1'b1;

        // Clear of CQ4 at the commit edge beats the update
        issue(16'h1024, 32'h3); exp_wr(4, 3);
        idle(); wait_cyc(5);
        issue(16'h1024, 32'h9); exp_err(0, 4);
        exp_head[4] = 0;
        idle();
        @(negedge clk); cq_rst_n[4] = 1'b0;
        @(negedge clk); cq_rst_n[4] = 1'b1;
        chk("cq4_cleared", int'(h4), 0);
        handle_err();
        check_heads();

        // Reset with a write sitting in stage 1
        issue(16'h103C, 32'h4);
        @(negedge clk);
        db_if.db_wr_en = 1'b0;
        rst_n = 1'b0;
        for (int q = 0; q < 9; q++) exp_head[q] = 0;
        @(negedge clk);
        check_heads();
        chk("midrst_ready", int'(db_if.db_wr_ready), 1);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(6);
        check_heads();
        chk("midrst_update", int'(cq_head_update), 0);

        chk("pulse_queue_drained", hq.size(), 0);
        chk("err_queue_drained", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
